// File: rtl/ins_mem_pkg.sv
// Shared constants, FSM state type and parity helper for the re-loadable
// instruction memory (ins_mem_prog / ins_mem_array).
// Optional feature macro: INS_MEM_PARITY_EN (enables per-entry parity storage).
package ins_mem_pkg;

  localparam int unsigned INS_W_DEF    = 11;
  localparam int unsigned ADDR_W_DEF   = 4;
  localparam logic [10:0] NOP_WORD_DEF = 11'b01100000000;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } ins_mem_state_e;

  // Even-parity bit of a word (callers zero-extend, which keeps the parity).
  function automatic logic parity(input logic [63:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/ins_mem_array.sv
// DEPTH x INS_W instruction storage: async reset of every entry to NOP_WORD,
// one synchronous write port, one registered read port.
// Ports:
//   clk, rst                 clock / async active-high reset
//   wr_en, wr_addr, wr_data  write port
//   wr_par_inj, rd_par_err   parity inject / registered parity error
//                            (only with INS_MEM_PARITY_EN)
//   rd_en, rd_addr           read request; when rd_en=0 or address is out of
//                            range the registered output is NOP_WORD
//   rd_data                  registered read data
module ins_mem_array
  import ins_mem_pkg::*;
#(
  parameter int unsigned       INS_W    = INS_W_DEF,
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DEPTH    = 1 << ADDR_W,
  parameter logic [INS_W-1:0]  NOP_WORD = INS_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INS_W-1:0]  wr_data,
`ifdef INS_MEM_PARITY_EN
  input  logic              wr_par_inj,
  output logic              rd_par_err,
`endif
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INS_W-1:0]  rd_data
);

  logic [INS_W-1:0] mem [DEPTH];
  logic             wr_in_range;
  logic             rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));

  // Storage: every entry returns to NOP_WORD on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
    end else if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= NOP_WORD;
    end else if (rd_en && rd_in_range) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= NOP_WORD;
    end
  end

`ifdef INS_MEM_PARITY_EN
  logic par_mem [DEPTH];

  // Stored even-parity bit; wr_par_inj corrupts it for test purposes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) par_mem[i] <= parity(64'(NOP_WORD));
    end else if (wr_en && wr_in_range) begin
      par_mem[wr_addr] <= parity(64'(wr_data)) ^ wr_par_inj;
    end
  end

  // Error flag travels with rd_data; zero whenever no real fetch happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_par_err <= 1'b0;
    end else if (rd_en && rd_in_range) begin
      rd_par_err <= (parity(64'(mem[rd_addr])) != par_mem[rd_addr]);
    end else begin
      rd_par_err <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ins_mem_prog.sv
// Re-loadable instruction memory with registered one-cycle fetch from PC and
// a valid/ready program-load port. RUN serves fetches; LOAD accepts words.
// Optional feature macro: INS_MEM_PARITY_EN (adds PAR_INJ input, PAR_ERR output).
// Ports:
//   CLK, RST      clock / async active-high reset
//   PC            fetch address
//   RES_INS       registered fetched instruction (NOP_WORD when not fetching)
//   INS_VALID     RES_INS holds a real fetch result
//   LOAD_START    pulse: start (or restart) a program load
//   LD_DATA/LD_VALID/LD_LAST/LD_READY  load handshake
//   LOAD_BUSY     in LOAD state
//   LD_COUNT      words written by the current or last load
module ins_mem_prog
  import ins_mem_pkg::*;
#(
  parameter int unsigned       INS_W    = INS_W_DEF,
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DEPTH    = 1 << ADDR_W,
  parameter logic [INS_W-1:0]  NOP_WORD = INS_W'(NOP_WORD_DEF)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC,
  output logic [INS_W-1:0]  RES_INS,
  output logic              INS_VALID,
  input  logic              LOAD_START,
  input  logic [INS_W-1:0]  LD_DATA,
  input  logic              LD_VALID,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              LOAD_BUSY,
  output logic [ADDR_W:0]   LD_COUNT
`ifdef INS_MEM_PARITY_EN
  ,
  input  logic              PAR_INJ,
  output logic              PAR_ERR
`endif
);

  ins_mem_state_e    state_q, state_d;
  logic [ADDR_W-1:0] wp_q;
  logic              wp_last;
  logic              xfer;
  logic              fetch;

  assign wp_last = (wp_q == ADDR_W'(DEPTH - 1));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: a restart pulse in LOAD discards the concurrent transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:  if (LOAD_START) state_d = LOAD;
      LOAD: if (!LOAD_START && LD_VALID && (LD_LAST || wp_last)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State-decoded controls and handshake outputs.
  always_comb begin
    LD_READY  = 1'b0;
    LOAD_BUSY = 1'b0;
    xfer      = 1'b0;
    fetch     = 1'b0;
    case (state_q)
      RUN:  fetch = !LOAD_START;
      LOAD: begin
        LD_READY  = 1'b1;
        LOAD_BUSY = 1'b1;
        xfer      = LD_VALID && !LOAD_START;
      end
      default: ;
    endcase
  end

  // Write pointer, load count and fetch-valid flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp_q      <= '0;
      LD_COUNT  <= '0;
      INS_VALID <= 1'b0;
    end else begin
      INS_VALID <= fetch;
      if (LOAD_START) begin
        wp_q     <= '0;
        LD_COUNT <= '0;
      end else if (xfer) begin
        // Exit happens at DEPTH-1, so the pointer parks there instead of wrapping.
        if (!wp_last) wp_q <= wp_q + ADDR_W'(1);
        if (LD_COUNT != (ADDR_W+1)'(DEPTH)) LD_COUNT <= LD_COUNT + (ADDR_W+1)'(1);
      end
    end
  end

  ins_mem_array #(
    .INS_W    (INS_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_WORD)
  ) u_array (
    .clk        (CLK),
    .rst        (RST),
    .wr_en      (xfer),
    .wr_addr    (wp_q),
    .wr_data    (LD_DATA),
`ifdef INS_MEM_PARITY_EN
    .wr_par_inj (PAR_INJ),
    .rd_par_err (PAR_ERR),
`endif
    .rd_en      (fetch),
    .rd_addr    (PC),
    .rd_data    (RES_INS)
  );

endmodule

// File: tb/tb_ins_mem_prog.sv
// Directed, table-driven bench for ins_mem_prog: fetch tables per phase plus
// hand-written load / restart / reset-in-load sequences.
module tb_ins_mem_prog;

  localparam logic [10:0] NOP = 11'b01100000000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  PC = '0;
  logic [10:0] RES_INS;
  logic        INS_VALID;
  logic        LOAD_START = 1'b0;
  logic [10:0] LD_DATA = '0;
  logic        LD_VALID = 1'b0;
  logic        LD_LAST = 1'b0;
  logic        LD_READY;
  logic        LOAD_BUSY;
  logic [4:0]  LD_COUNT;
`ifdef INS_MEM_PARITY_EN
  logic        PAR_INJ = 1'b0;
  logic        PAR_ERR;
`endif

  ins_mem_prog dut (
    .CLK        (CLK),
    .RST        (RST),
    .PC         (PC),
    .RES_INS    (RES_INS),
    .INS_VALID  (INS_VALID),
    .LOAD_START (LOAD_START),
    .LD_DATA    (LD_DATA),
    .LD_VALID   (LD_VALID),
    .LD_LAST    (LD_LAST),
    .LD_READY   (LD_READY),
    .LOAD_BUSY  (LOAD_BUSY),
    .LD_COUNT   (LD_COUNT)
`ifdef INS_MEM_PARITY_EN
    ,
    .PAR_INJ    (PAR_INJ),
    .PAR_ERR    (PAR_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          phase;
    logic [3:0]  pc;
    logic [10:0] ins;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [10:0] d3(int i);
    return 11'(i * 73 + 5);
  endfunction

  function automatic logic [10:0] d4(int i);
    return 11'(11'h600 + i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; presents PC, checks the result one edge later.
  task automatic fetch(input logic [3:0] pc, input logic [10:0] exp, input string name);
    PC = pc;
    @(negedge CLK);
    chk($sformatf("%s ins pc=%0d", name, pc), 32'(RES_INS), 32'(exp));
    chk($sformatf("%s valid pc=%0d", name, pc), 32'(INS_VALID), 32'd1);
  endtask

  task automatic run_phase(input int p, input string name);
    foreach (tbl[k]) if (tbl[k].phase == p) fetch(tbl[k].pc, tbl[k].ins, name);
  endtask

  task automatic start_load();
    LOAD_START = 1'b1;
    @(negedge CLK);
    LOAD_START = 1'b0;
  endtask

  task automatic put_word(input logic [10:0] d, input logic last);
    chk("ld_ready in load", 32'(LD_READY), 32'd1);
    LD_DATA  = d;
    LD_VALID = 1'b1;
    LD_LAST  = last;
    @(negedge CLK);
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    LD_DATA  = 11'h7FF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected fetch tables for each phase.
    for (int i = 0; i < 16; i++) tbl.push_back('{1, 4'(i), NOP});
    tbl.push_back('{2, 4'd0, 11'h406});
    tbl.push_back('{2, 4'd1, 11'h41D});
    tbl.push_back('{2, 4'd2, 11'h021});
    tbl.push_back('{2, 4'd3, NOP});
    for (int i = 0; i < 16; i++) tbl.push_back('{3, 4'(i), d3(i)});
    tbl.push_back('{4, 4'd0, 11'h555});
    for (int i = 1; i < 5; i++) tbl.push_back('{4, 4'(i), d4(i)});
    tbl.push_back('{4, 4'd5, d3(5)});
    tbl.push_back('{4, 4'd15, d3(15)});
    for (int i = 0; i < 16; i++) tbl.push_back('{5, 4'(i), NOP});

    // Reset state.
    @(negedge CLK);
    @(negedge CLK);
    chk("rst res_ins", 32'(RES_INS), 32'(NOP));
    chk("rst ins_valid", 32'(INS_VALID), 32'd0);
    chk("rst ld_ready", 32'(LD_READY), 32'd0);
    chk("rst load_busy", 32'(LOAD_BUSY), 32'd0);
    chk("rst ld_count", 32'(LD_COUNT), 32'd0);
    RST = 1'b0;

    // 1: fetch of reset contents.
    run_phase(1, "p1");

    // 2: short load terminated by LD_LAST.
    start_load();
    chk("p2 busy", 32'(LOAD_BUSY), 32'd1);
    chk("p2 valid low", 32'(INS_VALID), 32'd0);
    chk("p2 ins nop", 32'(RES_INS), 32'(NOP));
    chk("p2 count0", 32'(LD_COUNT), 32'd0);
    put_word(11'h406, 1'b0);
    put_word(11'h41D, 1'b0);
    chk("p2 busy mid", 32'(LOAD_BUSY), 32'd1);
    put_word(11'h021, 1'b1);
    chk("p2 busy done", 32'(LOAD_BUSY), 32'd0);
    chk("p2 count", 32'(LD_COUNT), 32'd3);
    chk("p2 exit valid", 32'(INS_VALID), 32'd0);
    chk("p2 ready run", 32'(LD_READY), 32'd0);
    run_phase(2, "p2");
    chk("p2 count hold", 32'(LD_COUNT), 32'd3);

    // 3: 16 words with LD_VALID gaps, auto-exit at the last entry.
    start_load();
    for (int i = 0; i < 16; i++) begin
      put_word(d3(i), 1'b0);
      if (i == 14) chk("p3 busy before end", 32'(LOAD_BUSY), 32'd1);
      if (i < 15) begin
        @(negedge CLK);  // LD_VALID=0 gap with junk data
        if (i == 7) chk("p3 count after gap", 32'(LD_COUNT), 32'd8);
      end
    end
    chk("p3 busy done", 32'(LOAD_BUSY), 32'd0);
    chk("p3 count", 32'(LD_COUNT), 32'd16);
    run_phase(3, "p3");

    // 4: restart at word 5; the concurrent transfer is dropped.
    start_load();
    for (int i = 0; i < 5; i++) put_word(d4(i), 1'b0);
    chk("p4 count5", 32'(LD_COUNT), 32'd5);
    LOAD_START = 1'b1;
    LD_VALID   = 1'b1;
    LD_DATA    = 11'h2AA;
    @(negedge CLK);
    LOAD_START = 1'b0;
    LD_VALID   = 1'b0;
    chk("p4 restart count", 32'(LD_COUNT), 32'd0);
    chk("p4 restart busy", 32'(LOAD_BUSY), 32'd1);
    put_word(11'h555, 1'b1);
    chk("p4 count", 32'(LD_COUNT), 32'd1);
    chk("p4 busy done", 32'(LOAD_BUSY), 32'd0);
    run_phase(4, "p4");

    // 5: async reset in the middle of a load.
    start_load();
    for (int i = 0; i < 4; i++) put_word(11'h123 + 11'(i), 1'b0);
    chk("p5 count4", 32'(LD_COUNT), 32'd4);
    #2 RST = 1'b1;
    #1;
    chk("p5 async busy", 32'(LOAD_BUSY), 32'd0);
    chk("p5 async ready", 32'(LD_READY), 32'd0);
    chk("p5 async count", 32'(LD_COUNT), 32'd0);
    chk("p5 async valid", 32'(INS_VALID), 32'd0);
    chk("p5 async ins", 32'(RES_INS), 32'(NOP));
    @(negedge CLK);
    RST = 1'b0;
    run_phase(5, "p5");

`ifdef INS_MEM_PARITY_EN
    // 6: injected parity error on entry 2.
    start_load();
    put_word(11'h111, 1'b0);
    put_word(11'h222, 1'b0);
    PAR_INJ = 1'b1;
    put_word(11'h333, 1'b1);
    PAR_INJ = 1'b0;
    PC = 4'd2;
    @(negedge CLK);
    chk("p6 ins pc2", 32'(RES_INS), 32'h333);
    chk("p6 par_err pc2", 32'(PAR_ERR), 32'd1);
    PC = 4'd1;
    @(negedge CLK);
    chk("p6 ins pc1", 32'(RES_INS), 32'h222);
    chk("p6 par_err pc1", 32'(PAR_ERR), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ins_mem_prog.md
Name: ins_mem_prog

Overview:
Parametrised, clocked, re-loadable instruction memory. Successor to the fixed 16-entry, 11-bit combinational instruction store.
- Holds DEPTH words of INS_W bits.
- Serves fetches from the PC with a registered one-cycle latency.
- Accepts a new program over a valid/ready load port.
- Sits between the PC register and instruction decode; the loader drives the load port from the test/boot side.

Parameters:
INS_W, 11, instruction word width in bits
ADDR_W, 4, PC/address width
DEPTH, 1<<ADDR_W, number of words; must be ≤ 2**ADDR_W
NOP_WORD, 11'b01100000000, reset contents of every entry and output during load

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
PC  in  ADDR_W  fetch address
RES_INS  out  INS_W  fetched instruction, registered
INS_VALID  out  1  RES_INS is a real fetch result; CPU stalls when 0
LOAD_START  in  1  single-cycle pulse: begin program load
LD_DATA  in  INS_W  word to write
LD_VALID  in  1  LD_DATA valid
LD_LAST  in  1  qualifies the final word of the program
LD_READY  out  1  memory accepts a word this cycle
LOAD_BUSY  out  1  high while in LOAD state
LD_COUNT  out  ADDR_W+1  words written by the current or last load

Behaviour:
- Reset (async, any time, including mid-load):
  - all entries = NOP_WORD, state = RUN
  - RES_INS = NOP_WORD, INS_VALID = 0, LD_READY = 0, LOAD_BUSY = 0, LD_COUNT = 0
  - write pointer WP = 0
- States: RUN, LOAD.
- RUN:
  - Each cycle, RES_INS <= mem[PC] and INS_VALID <= 1.
  - First valid fetch appears one cycle after reset release.
  - PC ≥ DEPTH: RES_INS <= NOP_WORD, INS_VALID <= 1.
  - LD_READY = 0.
- RUN -> LOAD: on LOAD_START = 1. Same edge:
  - WP <= 0, LD_COUNT <= 0
  - RES_INS <= NOP_WORD, INS_VALID <= 0
- LOAD:
  - LOAD_BUSY = 1; LD_READY = 1 (combinational, state-only).
  - INS_VALID held 0; RES_INS held NOP_WORD.
  - Transfer occurs when LD_VALID & LD_READY:
    - mem[WP] <= LD_DATA
    - WP <= WP+1
    - LD_COUNT <= LD_COUNT+1
  - LD_DATA is ignored when LD_VALID = 0.
- LOAD -> RUN: on a transfer with LD_LAST = 1, or a transfer at WP = DEPTH-1, whichever comes first.
  - Both true in the same cycle: single exit, no error.
  - Entries not written in this load keep their previous contents.
  - First valid fetch appears one cycle after the exit edge. It reads the newly written contents; no read-during-write hazard, since RUN and LOAD are exclusive.
- LOAD_START while in LOAD:
  - Restarts the load: WP <= 0, LD_COUNT <= 0.
  - A transfer in the same cycle is discarded.
- LD_VALID in RUN: ignored, no write.
- LD_COUNT holds its final value after exit until the next LOAD_START or reset.
- Arithmetic: WP is ADDR_W bits and never wraps, because exit occurs at DEPTH-1. LD_COUNT saturates at DEPTH.

Optional Feature:
Macro: INS_MEM_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from LD_DATA on write.
  - Extra output PAR_ERR (1 bit, registered, reset 0) goes high with RES_INS when the fetched word's parity mismatches; it is 0 while INS_VALID = 0.
  - Test-only input PAR_INJ (1 bit) inverts the stored parity bit on a write.
- Undefined: no parity storage; PAR_ERR and PAR_INJ ports are absent.

Decomposition:
- Package ins_mem_pkg:
  - default INS_W, ADDR_W, NOP_WORD constants
  - state enum {RUN, LOAD}
  - parity function
- One sub-module: ins_mem_array, a DEPTH×INS_W storage array with async reset to NOP_WORD, a single write port and a single registered read port (parity bit included under the macro).
- The FSM, pointer and handshake stay in ins_mem_prog.

Test Plan:
1. Reset, then PC=0..15 in RUN -> every RES_INS = 11'b01100000000, INS_VALID = 1 from the cycle after reset release.
2. LOAD_START, then 3 words 11'h406/11'h41D/11'h021 with LD_LAST on the third -> LOAD_BUSY falls after the third transfer, LD_COUNT = 3. Fetch PC=0,1,2,3 -> 11'h406, 11'h41D, 11'h021, NOP_WORD, each one cycle after PC.
3. Load with LD_VALID toggling 1,0,1,0,... for 16 words, no LD_LAST -> auto-exit after the 16th transfer, LD_COUNT = 16, all 16 entries correct, no spurious writes on LD_VALID = 0 cycles.
4. LOAD_START at word 5 of a load -> LD_COUNT restarts at 0. New word 0 overwrites entry 0; entries 1-4 keep first-load values if not rewritten.
5. Assert RST during LOAD after 4 words -> outputs at reset values immediately (asynchronously); all entries read back NOP_WORD after release.
6. With INS_MEM_PARITY_EN: write entry 2 with PAR_INJ = 1 -> fetch of PC=2 gives PAR_ERR = 1; PC=1 gives PAR_ERR = 0.
